// File: rtl/freq_gate_scheduler_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer.
package freq_meter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      GATE   = 3'd2,
      SETTLE = 3'd3,
      LATCH  = 3'd4,
      EVAL   = 3'd5
   } fgs_state_t;

   localparam logic [1:0] RANGE_100MS = 2'd0;
   localparam logic [1:0] RANGE_1S    = 2'd1;
   localparam logic [1:0] RANGE_10S   = 2'd2;

   // Range step decided at LATCH, applied when leaving EVAL.
   typedef struct packed {
      logic dn;
      logic up;
   } rng_adj_t;

   // Number of 0.1 s base ticks in one gate window.
   function automatic logic [6:0] gate_ticks(input logic [1:0] rng);
      case (rng)
         RANGE_100MS: gate_ticks = 7'd1;
         RANGE_1S:    gate_ticks = 7'd10;
         default:     gate_ticks = 7'd100;
      endcase
   endfunction

   // Range code 3 behaves as the 10 s range.
   function automatic logic [1:0] range_clamp(input logic [1:0] rng);
      range_clamp = (rng == 2'd3) ? RANGE_10S : rng;
   endfunction

endpackage

// File: rtl/freq_gate_scheduler_if.sv
// Control/counter-side signal bundle of the gate sequencer.
interface freq_gate_scheduler_if #(
   parameter int CNT_W = 32
) ();
   logic             run;
   logic             auto_en;
   logic [1:0]       manual_range;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_ovf;
   logic             count_en;
   logic             latch_en;
   logic             clear;
   logic [1:0]       gate_range;
   logic             result_valid;
   logic             result_ovf;
   logic             busy;

   modport slave (
      input  run, auto_en, manual_range, cnt_value, cnt_ovf,
      output count_en, latch_en, clear, gate_range, result_valid, result_ovf, busy
   );

   modport master (
      output run, auto_en, manual_range, cnt_value, cnt_ovf,
      input  count_en, latch_en, clear, gate_range, result_valid, result_ovf, busy
   );
endinterface

// File: rtl/freq_gate_scheduler_gate_timer.sv
// Gate window timer: TICK_DIV prescaler plus base-tick counter.
// start (held one cycle before the window) zeroes both counters, so the
// window length never depends on earlier, possibly aborted, windows.
module gate_timer #(
   parameter int TICK_DIV = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] n_ticks,
   output logic       done
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic [6:0]    gate_cnt;
   logic          active;

   assign done = active && (tick_cnt == TICK_LAST) && (gate_cnt == n_ticks - 7'd1);

   // Prescaler and tick counter; they stop after the last cycle of a window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         gate_cnt <= '0;
         active   <= 1'b0;
      end else if (start) begin
         tick_cnt <= '0;
         gate_cnt <= '0;
         active   <= 1'b1;
      end else if (active) begin
         if (done) active <= 1'b0;
         if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            gate_cnt <= gate_cnt + 7'd1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/freq_gate_scheduler.sv
// Gate sequencer for the frequency counter: clear -> gate -> settle ->
// latch -> evaluate, with optional auto-ranging of the gate time.
module freq_gate_scheduler
   import freq_meter_pkg::*;
#(
   parameter int TICK_DIV   = 5000000,
   parameter int SETTLE_CYC = 4,
   parameter int CNT_W      = 32,
   parameter int LO_TH      = 100,
   parameter int HI_TH      = 2000000000
) (
   input logic                  clk,
   input logic                  rst_n,
   freq_gate_scheduler_if.slave bus
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] LO_V = CNT_W'(LO_TH);
   localparam logic [CNT_W-1:0] HI_V = CNT_W'(HI_TH);

   fgs_state_t    state, state_nxt;
   logic [SW-1:0] settle_cnt;
   logic [1:0]    gate_range;
   logic          auto_q;
   rng_adj_t      adj_q, adj_nxt;
   logic [1:0]    rng_adj;
   logic          accept;
   logic          hi, lo;
   logic          tmr_done;
   logic          count_en_q, latch_en_q, clear_q, result_valid_q, result_ovf_q, busy_q;

   gate_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (state == CLEAR),
      .n_ticks (gate_ticks(gate_range)),
      .done    (tmr_done)
   );

   // Range decision from the values presented during LATCH. An overflow at
   // the shortest range cannot be cured by shortening, so it is reported.
   always_comb begin
      hi      = bus.cnt_ovf || (bus.cnt_value > HI_V);
      lo      = bus.cnt_value < LO_V;
      adj_nxt = '0;
      if (auto_q) begin
         if (hi) adj_nxt.dn = (gate_range > RANGE_100MS);
         else if (lo) adj_nxt.up = (gate_range < RANGE_10S);
      end
      accept  = !(adj_nxt.dn || adj_nxt.up);
      rng_adj = adj_q.dn ? gate_range - 2'd1 :
                adj_q.up ? gate_range + 2'd1 : gate_range;
   end

   // Next-state logic; run low before LATCH aborts the measurement.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.run) state_nxt = CLEAR;
         CLEAR:   state_nxt = bus.run ? GATE : IDLE;
         GATE:    if (!bus.run) state_nxt = IDLE;
                  else if (tmr_done) state_nxt = SETTLE;
         SETTLE:  if (!bus.run) state_nxt = IDLE;
                  else if (settle_cnt == SETTLE_LAST) state_nxt = LATCH;
         LATCH:   state_nxt = EVAL;
         EVAL:    state_nxt = bus.run ? CLEAR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, settle counter and registered Moore outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         count_en_q     <= 1'b0;
         latch_en_q     <= 1'b0;
         clear_q        <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         result_ovf_q   <= 1'b0;
      end else begin
         state          <= state_nxt;
         settle_cnt     <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
         count_en_q     <= (state_nxt == GATE);
         latch_en_q     <= (state_nxt == LATCH);
         clear_q        <= (state_nxt == CLEAR);
         busy_q         <= (state_nxt != IDLE);
         result_valid_q <= (state == LATCH) && accept;
         if ((state == LATCH) && accept) result_ovf_q <= bus.cnt_ovf;
      end
   end

   // Range bookkeeping: mode and manual range are taken only on entry to
   // CLEAR; an auto step is applied on leaving EVAL, never inside a gate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_range <= RANGE_1S;
         auto_q     <= 1'b0;
         adj_q      <= '0;
      end else begin
         if (state == LATCH) adj_q <= adj_nxt;
         if ((state_nxt == CLEAR) && (state != CLEAR)) begin
            auto_q <= bus.auto_en;
            if (!bus.auto_en)       gate_range <= range_clamp(bus.manual_range);
            else if (state == EVAL) gate_range <= rng_adj;
         end else if (state == EVAL) begin
            gate_range <= rng_adj;
         end
      end
   end

   assign bus.count_en     = count_en_q;
   assign bus.latch_en     = latch_en_q;
   assign bus.clear        = clear_q;
   assign bus.gate_range   = gate_range;
   assign bus.result_valid = result_valid_q;
   assign bus.result_ovf   = result_ovf_q;
   assign bus.busy         = busy_q;
endmodule

// File: doc/freq_gate_scheduler.md
Name: freq_gate_scheduler

Overview:
Sequencer for the frequency-meter counting datapath. It runs on the fast system clock and generates the counter's count_en, latch_en and clear.
- Produces exact gate windows of 0.1 s, 1 s or 10 s.
- Supports single and continuous measurement.
- Auto-ranges the gate time from the latched count and the counter's overflow flag.
- Sits between the control/UI logic and the counter/latch pair; result_valid feeds the display/readout.

Parameters:
TICK_DIV, 5000000, clk cycles per 0.1 s base tick (50 MHz clock)
SETTLE_CYC, 4, idle cycles after gate close before latching (drains the counter's input synchronizer)
CNT_W, 32, width of the counter value input
LO_TH, 100, auto-range: count below this means the gate is lengthened
HI_TH, 2000000000, auto-range: count above this means the gate is shortened

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = measure continuously; 0 = stop after abort
auto_en  in  1  1 = auto-range, 0 = manual range
manual_range  in  2  0=0.1 s, 1=1 s, 2=10 s, 3 treated as 2
cnt_value  in  CNT_W  counter output, valid from the LATCH cycle
cnt_ovf  in  1  counter overflow flag, valid with cnt_value
count_en  out  1  counter enable (gate window)
latch_en  out  1  one-cycle latch strobe
clear  out  1  one-cycle counter clear
gate_range  out  2  range used for the current/last measurement
result_valid  out  1  one-cycle pulse: latched result is final
result_ovf  out  1  overflow qualifier, held until next result_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - count_en, latch_en, clear, result_valid, result_ovf, busy = 0
  - gate_range = 1
  - tick and gate counters = 0
- Output timing: all outputs are registered and are a function of state only (Moore).
- States and transitions:
  - IDLE: if run=1, go to CLEAR. In manual mode, gate_range is loaded from manual_range at this transition.
  - CLEAR: exactly 1 cycle, clear=1. Then GATE.
  - GATE: count_en=1 for exactly N*TICK_DIV cycles, where N = 1, 10 or 100 for range 0/1/2.
    - The tick counter restarts at GATE entry, so the window is exact and independent of history.
    - Then SETTLE.
  - SETTLE: SETTLE_CYC cycles with all strobes low. Then LATCH.
  - LATCH: 1 cycle, latch_en=1. cnt_value and cnt_ovf are sampled at the end of this cycle. Then EVAL.
  - EVAL: 1 cycle.
    - Auto mode:
      - If sampled ovf=1 or value>HI_TH, and range>0: range-1, result discarded.
      - Else if value<LO_TH and range<2: range+1, result discarded.
      - Otherwise, keep the range and accept the result.
    - Manual mode: always accept the result.
    - On accept: result_valid=1 for 1 cycle; result_ovf = sampled ovf (this includes an overflow at range 0, which is reported, not retried).
    - Next state: CLEAR if run=1, else IDLE. In manual mode, manual_range is reloaded on the EVAL->CLEAR transition.
- Measurement period: 1 + N*TICK_DIV + SETTLE_CYC + 2 cycles.
- run deasserted in CLEAR, GATE or SETTLE: abort.
  - Next cycle: state IDLE, count_en=0.
  - No latch_en and no result_valid are produced.
  - gate_range keeps its value.
- run deasserted in LATCH or EVAL: the measurement completes, then the block goes to IDLE.
- Mid-measurement changes: auto_en and manual_range are sampled only on transitions into CLEAR.
- Strobe exclusivity: count_en, latch_en and clear are never high together. A range change never occurs while count_en=1.
- Async reset mid-gate: outputs drop immediately; the next measurement starts from range 1.
- Counter widths:
  - Tick counter: clog2(TICK_DIV) bits.
  - Gate tick counter: 7 bits (max 100).
  - No wrap occurs inside a window.

Decomposition:
- Package freq_meter_pkg holds:
  - state encoding: IDLE, CLEAR, GATE, SETTLE, LATCH, EVAL
  - range constants: RANGE_100MS = 0, RANGE_1S = 1, RANGE_10S = 2
  - function gate_ticks(range) returning 1, 10 or 100
- One sub-module, gate_timer, holds:
  - the TICK_DIV prescaler and the N-tick counter
  - inputs: start, n_ticks
  - output: done pulse on the last gate cycle

Test Plan:
All scenarios use TICK_DIV=10 and SETTLE_CYC=2.
1. Manual range 0, run held high -> clear 1 cycle, count_en exactly 10 cycles, latch_en 2 cycles after gate close, result_valid the cycle after latch; period 15 cycles, repeated.
2. Manual range 2 -> count_en high exactly 1000 cycles. manual_range=3 -> also 1000 cycles.
3. Auto mode, range 1, cnt_value=50 at LATCH -> no result_valid, next gate 1000 cycles, gate_range=2. Then cnt_value=500 -> result_valid=1, range stays 2.
4. Auto mode, range 1, cnt_ovf=1 -> range becomes 0, no valid. At range 0, cnt_ovf=1 again -> result_valid=1 with result_ovf=1, range stays 0.
5. run dropped 5 cycles into GATE -> count_en low next cycle, state IDLE, no latch_en/result_valid, busy=0. Raised again -> clear issued next cycle.
6. rst_n asserted mid-GATE (asynchronously, between clock edges) -> all outputs 0 immediately, gate_range=1. After release with run=1 -> normal 100-cycle gate.
